rs232_host_tx: RTL

- Host-side (DTE) RS-232 transmitter: the far end of the serial device's receive path.
- Buffers bytes from local logic in a FIFO and serialises them as start/data/parity/stop frames on `tx`.
- Drives `rts` to request transfer and waits for the device's `cts` before starting each frame.
- Used as a synthesizable link partner in loopback rigs and as a stand-alone host UART TX.

---
 rtl/rs232_host_tx_if.sv | 29 ++
 rtl/rs232_host_tx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rs232_host_tx_if.sv
// Byte-queue and serial-line signals of rs232_host_tx.
// master = local logic / device side, slave = the transmitter.
interface rs232_host_tx_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       data_in;
  logic             data_valid;
  logic             data_accepted;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic             tx;
  logic             rts;
  logic             cts;
  logic             tx_busy;
  logic             frame_sent;

  modport master (
    output data_in, data_valid, cts,
    input  data_accepted, fifo_full, fifo_empty, fifo_level, tx, rts, tx_busy, frame_sent
  );

  modport slave (
    input  data_in, data_valid, cts,
    output data_accepted, fifo_full, fifo_empty, fifo_level, tx, rts, tx_busy, frame_sent
  );
endinterface

// File: rtl/rs232_host_tx.sv
// Host-side RS-232 transmitter: byte FIFO, rts/cts handshake, start/data/parity/stop framing.
// Optional line break generator enabled by defining RS232_HOST_TX_BREAK_EN.
module rs232_host_tx #(
  parameter int CLK_TICKS_PER_RS232_BIT = 434,
  parameter int BYTE_LEN                = 8,
  parameter int PARITY                  = 1,
  parameter int STOP_BITS               = 0,
  parameter int FIFO_DEPTH              = 16,
  parameter int FLOW_CONTROL            = 1
) (
  input  logic clk,
  input  logic rst,
`ifdef RS232_HOST_TX_BREAK_EN
  input  logic send_break,
`endif
  rs232_host_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(CLK_TICKS_PER_RS232_BIT);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
`ifdef RS232_HOST_TX_BREAK_EN
    , S_BREAK
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q;
  logic [7:0]    head, shreg;
  logic [TW-1:0] tick_q;
  logic [3:0]    bit_q;
  logic          push, pop, full, empty, busy, start_ok, tick_done, brk_last;
  logic          acc_q, tx_q, tx_d, fs_q, fs_d, rts_q, par_q;
  logic          cts_meta, cts_sync;

  assign full      = level_q == LW'(FIFO_DEPTH);
  assign empty     = level_q == '0;
  assign push      = bus.data_valid && !full;
  assign head      = mem[rd_ptr];
  assign busy      = state_q != S_IDLE;
  assign tick_done = tick_q == '0;
  assign start_ok  = !empty && (cts_sync || FLOW_CONTROL == 0);

`ifdef RS232_HOST_TX_BREAK_EN
  assign brk_last = state_q == S_BREAK && bit_q == 4'(BYTE_LEN + 2);
`else
  assign brk_last = 1'b0;
`endif

  assign bus.data_accepted = acc_q;
  assign bus.fifo_full     = full;
  assign bus.fifo_empty    = empty;
  assign bus.fifo_level    = level_q;
  assign bus.tx            = tx_q;
  assign bus.rts           = rts_q;
  assign bus.tx_busy       = busy;
  assign bus.frame_sent    = fs_q;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.data_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      acc_q   <= 1'b0;
    end else begin
      acc_q <= push;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: ;
      endcase
    end
  end

  // Line value and frame_sent are registered together, so the whole frame
  // appears one cycle after the state that produces it, with no relative skew.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    fs_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
`ifdef RS232_HOST_TX_BREAK_EN
        if (send_break) state_d = S_BREAK;
        else
`endif
        if (start_ok) begin
          state_d = S_START;
          pop     = 1'b1;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (tick_done) state_d = S_DATA;
      end
      S_DATA: begin
        tx_d = shreg[0];
        if (tick_done && bit_q == 4'(BYTE_LEN - 1))
          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        tx_d = par_q;
        if (tick_done) state_d = S_STOP;
      end
      S_STOP: begin
        if (tick_done && bit_q == 4'(STOP_BITS)) begin
          fs_d = 1'b1;
          if (start_ok) begin
            state_d = S_START;
            pop     = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
`ifdef RS232_HOST_TX_BREAK_EN
      S_BREAK: begin
        tx_d = 1'b0;
        if (brk_last && tick_done && !send_break) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tx_q     <= 1'b1;
      fs_q     <= 1'b0;
      rts_q    <= 1'b0;
      cts_meta <= 1'b0;
      cts_sync <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      fs_q     <= fs_d;
      rts_q    <= (FLOW_CONTROL != 0) && (!empty || busy);
      cts_meta <= bus.cts;
      cts_sync <= cts_meta;
    end
  end

  // Reload on every state change keeps each bit exactly one period long;
  // a break that reached its minimum length parks the counter until released.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
      bit_q  <= '0;
    end else if (state_d != state_q) begin
      tick_q <= TW'(CLK_TICKS_PER_RS232_BIT - 1);
      bit_q  <= '0;
    end else if (busy) begin
      if (!tick_done) begin
        tick_q <= tick_q - TW'(1);
      end else if (!brk_last) begin
        tick_q <= TW'(CLK_TICKS_PER_RS232_BIT - 1);
        bit_q  <= bit_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      par_q <= 1'b0;
    end else if (pop) begin
      shreg <= head;
      par_q <= (^head[BYTE_LEN-1:0]) ^ (PARITY == 2);
    end else if (state_q == S_DATA && tick_done) begin
      shreg <= {1'b0, shreg[7:1]};
    end
  end
endmodule
